id_ex_operand_stage: RTL and testbench

- ID/EX pipeline register of the pipelined RISC-V core; sits directly upstream of the ALU and drives its ALUControl, a and b inputs.
- Captures decoded operands each cycle and applies EX/MEM and MEM/WB forwarding to the registered values.
- Detects load-use hazards, inserts bubbles on hazards, and honours external stall and flush.

---
 rtl/id_ex_operand_stage.sv | 145 ++++++++++++++
 tb/tb_id_ex_operand_stage.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX pipeline register with operand forwarding and load-use bubbles
module id_ex_operand_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [2:0]      id_alu_ctrl,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [XLEN-1:0] id_pc,
  input  logic            id_a_sel,
  input  logic            id_b_sel,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            mem_reg_write,
  input  logic [RA_W-1:0] mem_rd,
  input  logic [XLEN-1:0] mem_result,
  input  logic            wb_reg_write,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_result,
  output logic            load_use_stall,
  output logic            ex_valid,
  output logic [2:0]      alu_ctrl,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [XLEN-1:0] ex_store_data,
  output logic [RA_W-1:0] ex_rd,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic [XLEN-1:0] ex_pc
);

  typedef struct packed {
    logic            valid;
    logic [2:0]      alu_ctrl;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [RA_W-1:0] rd;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic            a_sel;
    logic            b_sel;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
  } stage_t;

  // An all-zero stage is the bubble: invalid, rd=x0, ALU op ADD, no side effects.
  localparam stage_t BUBBLE = '0;

  stage_t stage_q, stage_d;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;

  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [RA_W-1:0] src,
    input logic [XLEN-1:0] held,
    input logic            m_we,
    input logic [RA_W-1:0] m_rd,
    input logic [XLEN-1:0] m_val,
    input logic            w_we,
    input logic [RA_W-1:0] w_rd,
    input logic [XLEN-1:0] w_val
  );
    logic [XLEN-1:0] res;
    res = held;
    if (m_we && (m_rd != '0) && (m_rd == src)) begin
      res = m_val;
    end else if (w_we && (w_rd != '0) && (w_rd == src)) begin
      res = w_val;
    end
    return res;
  endfunction

  always_comb begin
    fwd_rs1 = fwd_sel(stage_q.rs1, stage_q.rs1_data, mem_reg_write, mem_rd, mem_result,
                      wb_reg_write, wb_rd, wb_result);
    fwd_rs2 = fwd_sel(stage_q.rs2, stage_q.rs2_data, mem_reg_write, mem_rd, mem_result,
                      wb_reg_write, wb_rd, wb_result);
  end

  // Conservative: any rs match counts, even when the operand is replaced by imm.
  assign load_use_stall = id_valid && stage_q.valid && stage_q.mem_read &&
                          (stage_q.rd != '0) &&
                          ((stage_q.rd == id_rs1) || (stage_q.rd == id_rs2));

  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      stage_d = BUBBLE;
    end else if (stall) begin
      // Keep the instruction but latch forwarded data so a retiring WB value survives.
      stage_d.rs1_data = fwd_rs1;
      stage_d.rs2_data = fwd_rs2;
    end else if (load_use_stall) begin
      stage_d = BUBBLE;
    end else begin
      stage_d.valid     = id_valid;
      stage_d.alu_ctrl  = id_alu_ctrl;
      stage_d.rs1       = id_rs1;
      stage_d.rs2       = id_rs2;
      stage_d.rd        = id_rd;
      stage_d.rs1_data  = id_rs1_data;
      stage_d.rs2_data  = id_rs2_data;
      stage_d.imm       = id_imm;
      stage_d.pc        = id_pc;
      stage_d.a_sel     = id_a_sel;
      stage_d.b_sel     = id_b_sel;
      stage_d.reg_write = id_reg_write;
      stage_d.mem_read  = id_mem_read;
      stage_d.mem_write = id_mem_write;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= BUBBLE;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign ex_valid      = stage_q.valid;
  assign alu_ctrl      = stage_q.alu_ctrl;
  assign alu_a         = stage_q.a_sel ? stage_q.pc : fwd_rs1;
  assign alu_b         = stage_q.b_sel ? stage_q.imm : fwd_rs2;
  assign ex_store_data = fwd_rs2;
  assign ex_rd         = stage_q.rd;
  assign ex_reg_write  = stage_q.reg_write;
  assign ex_mem_read   = stage_q.mem_read;
  assign ex_mem_write  = stage_q.mem_write;
  assign ex_pc         = stage_q.pc;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb/tb_id_ex_operand_stage.sv - directed and randomized checks of id_ex_operand_stage against a reference model
module tb_id_ex_operand_stage;
  localparam int XLEN = 32;
  localparam int RA_W = 5;

  logic clk = 1'b0;
  logic rst;
  logic stall, flush, id_valid;
  logic [2:0] id_alu_ctrl;
  logic [RA_W-1:0] id_rs1, id_rs2, id_rd;
  logic [XLEN-1:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
  logic id_a_sel, id_b_sel, id_reg_write, id_mem_read, id_mem_write;
  logic mem_reg_write, wb_reg_write;
  logic [RA_W-1:0] mem_rd, wb_rd;
  logic [XLEN-1:0] mem_result, wb_result;
  logic load_use_stall, ex_valid;
  logic [2:0] alu_ctrl;
  logic [XLEN-1:0] alu_a, alu_b, ex_store_data, ex_pc;
  logic [RA_W-1:0] ex_rd;
  logic ex_reg_write, ex_mem_read, ex_mem_write;

  always #5 clk = ~clk;

  id_ex_operand_stage #(.XLEN(XLEN), .RA_W(RA_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_alu_ctrl(id_alu_ctrl), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_pc(id_pc),
    .id_a_sel(id_a_sel), .id_b_sel(id_b_sel), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
    .load_use_stall(load_use_stall), .ex_valid(ex_valid), .alu_ctrl(alu_ctrl),
    .alu_a(alu_a), .alu_b(alu_b), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_pc(ex_pc)
  );

  // Model of the instruction currently sitting in EX.
  typedef struct packed {
    logic valid;
    logic [2:0] ctrl;
    logic [RA_W-1:0] rs1, rs2, rd;
    logic [XLEN-1:0] d1, d2, imm, pc;
    logic asel, bsel, rw, mr, mw;
  } ex_t;

  ex_t m;
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] fwd(input logic [RA_W-1:0] src, input logic [XLEN-1:0] d);
    if (mem_reg_write && mem_rd != '0 && mem_rd == src) return mem_result;
    if (wb_reg_write && wb_rd != '0 && wb_rd == src) return wb_result;
    return d;
  endfunction

  function automatic logic m_lus();
    return id_valid && m.valid && m.mr && (m.rd != '0) && (m.rd == id_rs1 || m.rd == id_rs2);
  endfunction

  task automatic check_all(input string ctx);
    check({ctx, ".lus"}, 32'(load_use_stall), 32'(m_lus()));
    check({ctx, ".valid"}, 32'(ex_valid), 32'(m.valid));
    check({ctx, ".ctrl"}, 32'(alu_ctrl), 32'(m.ctrl));
    check({ctx, ".alu_a"}, alu_a, m.asel ? m.pc : fwd(m.rs1, m.d1));
    check({ctx, ".alu_b"}, alu_b, m.bsel ? m.imm : fwd(m.rs2, m.d2));
    check({ctx, ".store"}, ex_store_data, fwd(m.rs2, m.d2));
    check({ctx, ".rd"}, 32'(ex_rd), 32'(m.rd));
    check({ctx, ".ctl"}, 32'({ex_reg_write, ex_mem_read, ex_mem_write}), 32'({m.rw, m.mr, m.mw}));
    check({ctx, ".pc"}, ex_pc, m.pc);
  endtask

  task automatic settle(input string ctx);
    #1;
    check_all(ctx);
  endtask

  // Advance one clock edge, updating the model from the inputs present at that edge.
  task automatic tick();
    ex_t n;
    if (flush) begin
      n = '0;
    end else if (stall) begin
      n = m;
      n.d1 = fwd(m.rs1, m.d1);
      n.d2 = fwd(m.rs2, m.d2);
    end else if (m_lus()) begin
      n = '0;
    end else begin
      n.valid = id_valid; n.ctrl = id_alu_ctrl;
      n.rs1 = id_rs1; n.rs2 = id_rs2; n.rd = id_rd;
      n.d1 = id_rs1_data; n.d2 = id_rs2_data; n.imm = id_imm; n.pc = id_pc;
      n.asel = id_a_sel; n.bsel = id_b_sel;
      n.rw = id_reg_write; n.mr = id_mem_read; n.mw = id_mem_write;
    end
    @(posedge clk);
    m = n;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; id_valid = 0; id_alu_ctrl = 3'b000;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_rs1_data = '0; id_rs2_data = '0; id_imm = '0; id_pc = '0;
    id_a_sel = 0; id_b_sel = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    mem_reg_write = 0; mem_rd = '0; mem_result = '0;
    wb_reg_write = 0; wb_rd = '0; wb_result = '0;
  endtask

  task automatic rand_inputs();
    stall = ($urandom_range(0, 7) == 0);
    flush = ($urandom_range(0, 15) == 0);
    id_valid = ($urandom_range(0, 3) != 0);
    id_alu_ctrl = 3'($urandom_range(0, 6));
    id_rs1 = 5'($urandom_range(0, 7));
    id_rs2 = 5'($urandom_range(0, 7));
    id_rd = 5'($urandom_range(0, 7));
    id_rs1_data = $urandom(); id_rs2_data = $urandom();
    id_imm = $urandom(); id_pc = $urandom();
    id_a_sel = ($urandom_range(0, 3) == 0);
    id_b_sel = ($urandom_range(0, 2) == 0);
    id_reg_write = ($urandom_range(0, 1) == 1);
    id_mem_read = ($urandom_range(0, 2) == 0);
    id_mem_write = ($urandom_range(0, 4) == 0);
    mem_reg_write = ($urandom_range(0, 1) == 1);
    mem_rd = 5'($urandom_range(0, 7));
    mem_result = $urandom();
    wb_reg_write = ($urandom_range(0, 1) == 1);
    wb_rd = 5'($urandom_range(0, 7));
    wb_result = $urandom();
  endtask

  initial begin
    m = '0;
    idle_inputs();
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    settle("reset");

    // Put a real instruction in EX, then reset asynchronously while stalled.
    id_valid = 1; id_alu_ctrl = 3'b110; id_rd = 5'd9; id_reg_write = 1;
    id_rs1 = 5'd1; id_rs1_data = 32'hDEAD_BEEF;
    tick();
    stall = 1;
    settle("pre_rst");
    #2 rst = 1;
    #1;
    check("async_rst.valid", 32'(ex_valid), 32'd0);
    check("async_rst.ctrl", 32'(alu_ctrl), 32'd0);
    check("async_rst.lus", 32'(load_use_stall), 32'd0);
    check("async_rst.rd", 32'(ex_rd), 32'd0);
    m = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    idle_inputs();
    settle("post_rst");

    // add x3, x1, x2 with x1=5, x2=7
    id_valid = 1; id_alu_ctrl = 3'b000; id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = 5'd3;
    id_rs1_data = 32'd5; id_rs2_data = 32'd7; id_reg_write = 1;
    tick();
    #1;
    check("add.alu_a", alu_a, 32'd5);
    check("add.alu_b", alu_b, 32'd7);
    check("add.ctrl", 32'(alu_ctrl), 32'd0);
    check("add.rd", 32'(ex_rd), 32'd3);
    check_all("add");

    // Forwarding priority on rs1=4
    idle_inputs();
    id_valid = 1; id_rs1 = 5'd4; id_rs1_data = 32'hAA; id_rd = 5'd8; id_alu_ctrl = 3'b001;
    tick();
    id_valid = 0;
    mem_reg_write = 1; mem_rd = 5'd4; mem_result = 32'h11;
    wb_reg_write = 1; wb_rd = 5'd4; wb_result = 32'h22;
    #1 check("fwd.mem_wins", alu_a, 32'h11);
    mem_reg_write = 0;
    #1 check("fwd.wb", alu_a, 32'h22);
    mem_reg_write = 1; mem_rd = 5'd0; mem_result = 32'h99; wb_reg_write = 0;
    #1 check("fwd.x0_none", alu_a, 32'hAA);
    check_all("fwd");

    // Load-use: lw x5 in EX, ID reads x5 as rs2
    idle_inputs();
    id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_rd = 5'd5; id_rs1 = 5'd2;
    tick();
    idle_inputs();
    id_valid = 1; id_rs1 = 5'd1; id_rs2 = 5'd5; id_rd = 5'd7; id_reg_write = 1; id_alu_ctrl = 3'b010;
    #1 check("lu.stall", 32'(load_use_stall), 32'd1);
    tick();
    #1;
    check("lu.bubble_valid", 32'(ex_valid), 32'd0);
    check("lu.bubble_rw", 32'(ex_reg_write), 32'd0);
    check("lu.released", 32'(load_use_stall), 32'd0);
    tick();
    #1;
    check("lu.enter_valid", 32'(ex_valid), 32'd1);
    check("lu.enter_rd", 32'(ex_rd), 32'd7);
    check_all("lu");

    // Stall refresh keeps a retiring WB value
    idle_inputs();
    id_valid = 1; id_rs1 = 5'd6; id_rs1_data = 32'd0; id_alu_ctrl = 3'b011; id_rd = 5'd10;
    tick();
    idle_inputs();
    stall = 1; wb_reg_write = 1; wb_rd = 5'd6; wb_result = 32'h1234;
    #1 check("stall.fwd", alu_a, 32'h1234);
    tick();
    wb_reg_write = 0;
    #1 check("stall.kept", alu_a, 32'h1234);
    check_all("stall");

    // Flush beats stall
    flush = 1;
    tick();
    flush = 0; stall = 0;
    #1;
    check("flush.ctrl", 32'(alu_ctrl), 32'd0);
    check("flush.valid", 32'(ex_valid), 32'd0);
    check_all("flush");

    // Operand select with forwarded rs2 for store data
    idle_inputs();
    id_valid = 1; id_a_sel = 1; id_pc = 32'h100; id_b_sel = 1; id_imm = 32'hFFFF_FFFC;
    id_rs2 = 5'd9; id_rs2_data = 32'h55; id_mem_write = 1;
    tick();
    idle_inputs();
    mem_reg_write = 1; mem_rd = 5'd9; mem_result = 32'h77;
    #1;
    check("sel.alu_a", alu_a, 32'h100);
    check("sel.alu_b", alu_b, 32'hFFFF_FFFC);
    check("sel.store", ex_store_data, 32'h77);
    check_all("sel");

    // Randomized run against the model
    for (int i = 0; i < 600; i++) begin
      rand_inputs();
      settle("rand");
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end

endmodule
